// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and the serial engine state encoding.
package uart_pkg;

   localparam logic [3:0] UART_TXDATA  = 4'h0;
   localparam logic [3:0] UART_STATUS  = 4'h4;
   localparam logic [3:0] UART_BAUDDIV = 4'h8;

   localparam int ST_BUSY  = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_EMPTY = 2;
   localparam int ST_OVF   = 3;
   localparam int ST_CNT   = 4;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/uart_tx_responder_tx_fifo.sv
// Byte-wide synchronous TX FIFO with show-ahead read data; count updates one edge after push/pop.
// Pushes into a full FIFO are ignored even if a pop happens on the same edge; pops when empty are ignored.
module tx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               wdata,
   output logic [7:0]               rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign full      = (r_count == FULL_CNT);
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign rdata     = r_mem[r_rptr];
   assign w_do_push = push & ~full;
   assign w_do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wptr] <= wdata;
      end
   end

   // Pointers wrap for free because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_responder.sv
// Bus-responder UART transmitter: zero-latency reads, writes take effect at the edge, 8N1 serial out.
// No bus backpressure: TXDATA writes to a full FIFO are dropped and flagged in sticky STATUS.ovf.
module uart_tx_responder
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h4000_0010,
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [15:0] DEFAULT_DIV = 16'd10415
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic        Mem_rd,
   input  logic        Mem_wr,
   input  logic [31:0] Write_data,
   output logic [31:0] Read_data,
   output logic        uart_tx,
   output logic        irq_tx_empty
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]   w_off;
   logic          w_hit;
   logic [3:0]    w_reg;
   logic          w_wr_tx;
   logic          w_wr_st;
   logic          w_wr_bd;
   logic          w_pop;
   logic          w_tick;
   logic [7:0]    w_rdata;
   logic [CW-1:0] w_count;
   logic [2:0]    w_cnt3;
   logic          w_full;
   logic          w_empty;
   logic [31:0]   w_status;
   logic          w_unused;

   tx_state_e     r_state;
   logic          r_tx;
   logic          r_ovf;
   logic [15:0]   r_baud;
   logic [15:0]   r_div_q;
   logic [15:0]   r_cnt;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;

   // Subtracting the base keeps the decode correct for any word-aligned BASE_ADDR.
   assign w_off   = {addr[31:2], 2'b00} - BASE_ADDR;
   assign w_hit   = (w_off[31:4] == 28'd0);
   assign w_reg   = w_off[3:0];
   assign w_wr_tx = Mem_wr & w_hit & (w_reg == UART_TXDATA);
   assign w_wr_st = Mem_wr & w_hit & (w_reg == UART_STATUS);
   assign w_wr_bd = Mem_wr & w_hit & (w_reg == UART_BAUDDIV);
   assign w_pop   = (r_state == TX_IDLE) & ~w_empty;
   assign w_tick  = (r_cnt == r_div_q);
   assign w_cnt3  = 3'(w_count);

   assign w_unused = ^{addr[1:0], Write_data[31:16]};

   tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_wr_tx),
      .pop   (w_pop),
      .wdata (Write_data[7:0]),
      .rdata (w_rdata),
      .count (w_count),
      .full  (w_full),
      .empty (w_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ovf  <= 1'b0;
         r_baud <= DEFAULT_DIV;
      end else begin
         if (w_wr_tx && w_full) begin
            r_ovf <= 1'b1;
         end else if (w_wr_st && Write_data[ST_OVF]) begin
            r_ovf <= 1'b0;
         end
         if (w_wr_bd) r_baud <= Write_data[15:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (r_state == TX_IDLE || w_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

   // The line level is registered on each state/bit advance so uart_tx never glitches.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= TX_IDLE;
         r_tx    <= 1'b1;
         r_div_q <= '0;
         r_bit   <= '0;
         r_shift <= '0;
      end else begin
         case (r_state)
            TX_IDLE: begin
               if (!w_empty) begin
                  r_state <= TX_START;
                  r_shift <= w_rdata;
                  r_div_q <= r_baud;
                  r_bit   <= '0;
                  r_tx    <= 1'b0;
               end
            end
            TX_START: begin
               if (w_tick) begin
                  r_state <= TX_DATA;
                  r_tx    <= r_shift[0];
               end
            end
            TX_DATA: begin
               if (w_tick) begin
                  if (r_bit == 3'd7) begin
                     r_state <= TX_STOP;
                     r_tx    <= 1'b1;
                  end else begin
                     r_bit <= r_bit + 3'd1;
                     r_tx  <= r_shift[r_bit + 3'd1];
                  end
               end
            end
            TX_STOP: begin
               if (w_tick) r_state <= TX_IDLE;
            end
            default: begin
               r_state <= TX_IDLE;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      w_status           = '0;
      w_status[ST_BUSY]  = (r_state != TX_IDLE);
      w_status[ST_FULL]  = w_full;
      w_status[ST_EMPTY] = w_empty;
      w_status[ST_OVF]   = r_ovf;
      w_status[ST_CNT +: 3] = w_cnt3;
   end

   always_comb begin
      Read_data = '0;
      if (Mem_rd && w_hit) begin
         case (w_reg)
            UART_STATUS:  Read_data = w_status;
            UART_BAUDDIV: Read_data = {16'h0000, r_baud};
            default:      Read_data = '0;
         endcase
      end
   end

   assign uart_tx      = r_tx;
   assign irq_tx_empty = w_empty & (r_state == TX_IDLE);

endmodule
